// File: rtl/fpaddsub_normalize_module.sv
// rtl/fpaddsub_normalize_module.sv - 2-stage post-add normalizer (LZC, shift, exponent adjust, G/R/S).
// Optional macro FPADDSUB_NORM_DENORM_EN: produce subnormals on underflow instead of flushing to zero.
module fpaddsub_normalize_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        InValid,
    output logic        InReady,
    input  logic [32:0] Sum,
    input  logic        PSgn,
    input  logic        Opr,
    input  logic [7:0]  Emax,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [22:0] NormM,
    output logic [7:0]  NormE,
    output logic        G,
    output logic        R,
    output logic        S,
    output logic        Sign,
    output logic        Zero,
    output logic        Ovf,
    output logic        Unf
);

    logic        r_s1_valid;
    logic [32:0] r_s1_sum;
    logic        r_s1_psgn;
    logic        r_s1_opr;
    logic [7:0]  r_s1_emax;
    logic [5:0]  r_s1_lzc;

    logic        r_s2_valid;
    logic [22:0] r_norm_m;
    logic [7:0]  r_norm_e;
    logic        r_g, r_r, r_s, r_sign, r_zero, r_ovf, r_unf;

    logic        w_s2_adv;
    logic [5:0]  w_lzc;
    logic        w_found;

    logic [5:0]        w_shamt;
    logic signed [9:0] w_exp_norm;
    logic [9:0]        w_exp_carry;
    logic              w_under;
    logic [30:0]       w_win;
    logic              w_sticky;
    logic              w_flush;
    logic [7:0]        w_e;
    logic [22:0]       w_m;
    logic              w_g, w_r, w_s, w_sign, w_zero, w_ovf, w_unf;
`ifdef FPADDSUB_NORM_DENORM_EN
    logic              w_den;
`endif

    assign w_s2_adv = !r_s2_valid || OutReady;
    assign InReady  = !r_s1_valid || w_s2_adv;

    always_comb begin
        w_lzc   = 6'd33;
        w_found = 1'b0;
        for (int i = 32; i >= 0; i--) begin
            if (!w_found && Sum[i]) begin
                w_lzc   = 6'(32 - i);
                w_found = 1'b1;
            end
        end
    end

    // Exponent math is 10-bit signed so a deep cancellation can never wrap into NormE.
    assign w_shamt     = r_s1_lzc - 6'd1;
    assign w_exp_norm  = $signed({2'b00, r_s1_emax}) - $signed({4'b0000, r_s1_lzc}) + 10'sd1;
    assign w_exp_carry = {2'b00, r_s1_emax} + 10'd1;
    assign w_under     = w_exp_norm < 10'sd1;

    always_comb begin
        w_win    = '0;
        w_sticky = 1'b0;
        w_flush  = 1'b0;
        w_e      = '0;
        w_zero   = 1'b0;
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        w_sign   = r_s1_psgn;
`ifdef FPADDSUB_NORM_DENORM_EN
        w_den    = 1'b0;
`endif
        if (r_s1_lzc == 6'd33) begin
            w_zero = 1'b1;
            w_sign = r_s1_opr ? 1'b0 : r_s1_psgn;
        end else if (r_s1_sum[32]) begin
            w_win    = r_s1_sum[31:1];
            w_sticky = r_s1_sum[0];
            if (w_exp_carry == 10'd255) begin
                w_ovf   = 1'b1;
                w_flush = 1'b1;
                w_e     = 8'hFF;
            end else begin
                w_e = w_exp_carry[7:0];
            end
        end else if (!w_under) begin
            w_win = 31'(r_s1_sum[30:0] << w_shamt);
            w_e   = w_exp_norm[7:0];
        end else begin
`ifdef FPADDSUB_NORM_DENORM_EN
            w_win = 31'(r_s1_sum[30:0] << (r_s1_emax - 8'd1));
            w_den = 1'b1;
`else
            w_unf   = 1'b1;
            w_flush = 1'b1;
`endif
        end
        w_m = w_flush ? 23'd0 : w_win[30:8];
        w_g = !w_flush && w_win[7];
        w_r = !w_flush && w_win[6];
        w_s = !w_flush && ((|w_win[5:0]) || w_sticky);
`ifdef FPADDSUB_NORM_DENORM_EN
        if (w_den) begin
            w_unf = w_g || w_r || w_s;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_psgn  <= 1'b0;
            r_s1_opr   <= 1'b0;
            r_s1_emax  <= '0;
            r_s1_lzc   <= '0;
            r_s2_valid <= 1'b0;
            r_norm_m   <= '0;
            r_norm_e   <= '0;
            r_g        <= 1'b0;
            r_r        <= 1'b0;
            r_s        <= 1'b0;
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            if (InReady) begin
                r_s1_valid <= InValid;
                if (InValid) begin
                    r_s1_sum  <= Sum;
                    r_s1_psgn <= PSgn;
                    r_s1_opr  <= Opr;
                    r_s1_emax <= Emax;
                    r_s1_lzc  <= w_lzc;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_norm_m <= w_m;
                    r_norm_e <= w_e;
                    r_g      <= w_g;
                    r_r      <= w_r;
                    r_s      <= w_s;
                    r_sign   <= w_sign;
                    r_zero   <= w_zero;
                    r_ovf    <= w_ovf;
                    r_unf    <= w_unf;
                end
            end
        end
    end

    assign OutValid = r_s2_valid;
    assign NormM    = r_norm_m;
    assign NormE    = r_norm_e;
    assign G        = r_g;
    assign R        = r_r;
    assign S        = r_s;
    assign Sign     = r_sign;
    assign Zero     = r_zero;
    assign Ovf      = r_ovf;
    assign Unf      = r_unf;

endmodule

// File: tb/tb_fpaddsub_normalize_module.sv
// tb/tb_fpaddsub_normalize_module.sv - scoreboard bench for fpaddsub_normalize_module.
// Expectations for underflow vectors follow FPADDSUB_NORM_DENORM_EN.
module tb_fpaddsub_normalize_module;

    logic        clk;
    logic        rst;
    logic        InValid;
    logic        InReady;
    logic [32:0] Sum;
    logic        PSgn;
    logic        Opr;
    logic [7:0]  Emax;
    logic        OutValid;
    logic        OutReady;
    logic [22:0] NormM;
    logic [7:0]  NormE;
    logic        G, R, S, Sign, Zero, Ovf, Unf;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sent   = 0;

    logic [37:0] exp_q[$];
    int          id_q[$];

    logic [37:0] mon_got;
    logic [37:0] mon_want;
    int          mon_id;

    fpaddsub_normalize_module dut (
        .clk      (clk),
        .rst      (rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .Sum      (Sum),
        .PSgn     (PSgn),
        .Opr      (Opr),
        .Emax     (Emax),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .NormM    (NormM),
        .NormE    (NormE),
        .G        (G),
        .R        (R),
        .S        (S),
        .Sign     (Sign),
        .Zero     (Zero),
        .Ovf      (Ovf),
        .Unf      (Unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] ex(input logic [22:0] m, input logic [7:0] e,
                                       input logic g, input logic r, input logic s,
                                       input logic sg, input logic z, input logic o,
                                       input logic u);
        return {m, e, g, r, s, sg, z, o, u};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic send(input logic [32:0] sm, input logic ps, input logic op,
                        input logic [7:0] em, input logic [37:0] want);
        int waited;
        Sum     = sm;
        PSgn    = ps;
        Opr     = op;
        Emax    = em;
        InValid = 1'b1;
        exp_q.push_back(want);
        id_q.push_back(n_sent);
        n_sent++;
        waited = 0;
        @(negedge clk);
        while (!InReady && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!InReady) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: vector %0d not accepted", n_sent - 1);
        end
        @(posedge clk);
        #1 InValid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every output handshake is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && OutValid && OutReady) begin
            mon_got = {NormM, NormE, G, R, S, Sign, Zero, Ovf, Unf};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %0h expected none", mon_got);
            end else begin
                mon_want = exp_q.pop_front();
                mon_id   = id_q.pop_front();
                if (mon_got !== mon_want) begin
                    n_fail++;
                    $display("FAIL result_%0d: got %0h expected %0h", mon_id, mon_got, mon_want);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        Sum      = '0;
        PSgn     = 1'b0;
        Opr      = 1'b0;
        Emax     = '0;
        repeat (2) @(negedge clk);
        chk("reset_outvalid", 64'(OutValid), 64'd0);
        chk("reset_inready", 64'(InReady), 64'd1);
        chk("reset_data", 64'({NormM, NormE, G, R, S, Sign, Zero, Ovf, Unf}), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        send(33'h0_8000_0000, 1'b0, 1'b0, 8'd127, ex(23'h0, 8'd127, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("latency_edge1", 64'(OutValid), 64'd0);
        @(negedge clk);
        chk("latency_edge2", 64'(OutValid), 64'd1);
        @(posedge clk);
        #1;

        send(33'h1_0000_0100, 1'b0, 1'b0, 8'd127, ex(23'h0, 8'd128, 1, 0, 0, 0, 0, 0, 0));
        send(33'h1_0000_0100, 1'b1, 1'b0, 8'd254, ex(23'h0, 8'd255, 0, 0, 0, 1, 0, 1, 0));
        send(33'h0_0000_8000, 1'b1, 1'b1, 8'd100, ex(23'h0, 8'd84, 0, 0, 0, 1, 0, 0, 0));
        send(33'h0_0000_0000, 1'b1, 1'b1, 8'd50,  ex(23'h0, 8'd0, 0, 0, 0, 0, 1, 0, 0));
        send(33'h0_0000_0000, 1'b1, 1'b0, 8'd50,  ex(23'h0, 8'd0, 0, 0, 0, 1, 1, 0, 0));
`ifdef FPADDSUB_NORM_DENORM_EN
        send(33'h0_0000_8000, 1'b1, 1'b0, 8'd3,   ex(23'h000200, 8'd0, 0, 0, 0, 1, 0, 0, 0));
        send(33'h0_0000_0001, 1'b0, 1'b0, 8'd2,   ex(23'h0, 8'd0, 0, 0, 1, 0, 0, 0, 1));
`else
        send(33'h0_0000_8000, 1'b1, 1'b0, 8'd3,   ex(23'h0, 8'd0, 0, 0, 0, 1, 0, 0, 1));
        send(33'h0_0000_0001, 1'b0, 1'b0, 8'd2,   ex(23'h0, 8'd0, 0, 0, 0, 0, 0, 0, 1));
`endif
        send(33'h1_0000_0001, 1'b0, 1'b0, 8'd10,  ex(23'h0, 8'd11, 0, 0, 1, 0, 0, 0, 0));
        send(33'h0_C000_00FF, 1'b0, 1'b0, 8'd50,  ex(23'h400000, 8'd50, 1, 1, 1, 0, 0, 0, 0));
        send(33'h0_4000_0040, 1'b0, 1'b0, 8'd20,  ex(23'h0, 8'd19, 1, 0, 0, 0, 0, 0, 0));
        send(33'h0_0000_8000, 1'b0, 1'b0, 8'd17,  ex(23'h0, 8'd1, 0, 0, 0, 0, 0, 0, 0));
        send(33'h0_8000_0000, 1'b0, 1'b0, 8'd1,   ex(23'h0, 8'd1, 0, 0, 0, 0, 0, 0, 0));
        drain();

        // Backpressure: two accepted, third stalls until the output is released.
        @(posedge clk);
        #1 OutReady = 1'b0;
        send(33'h0_A000_0000, 1'b0, 1'b0, 8'd60, ex(23'h200000, 8'd60, 0, 0, 0, 0, 0, 0, 0));
        send(33'h0_6000_0000, 1'b1, 1'b0, 8'd61, ex(23'h400000, 8'd60, 0, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        chk("inready_drop", 64'(InReady), 64'd0);
        chk("stall_outvalid", 64'(OutValid), 64'd1);
        fork
            send(33'h1_2000_0000, 1'b0, 1'b0, 8'd62, ex(23'h100000, 8'd63, 0, 0, 0, 0, 0, 0, 0));
            begin
                repeat (5) @(posedge clk);
                #1 OutReady = 1'b1;
            end
        join
        drain();

        // Reset with both stages occupied.
        @(posedge clk);
        #1 OutReady = 1'b0;
        send(33'h0_8000_0000, 1'b0, 1'b0, 8'd30, ex(23'h0, 8'd30, 0, 0, 0, 0, 0, 0, 0));
        send(33'h0_8000_0000, 1'b0, 1'b0, 8'd31, ex(23'h0, 8'd31, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("full_before_rst", 64'({OutValid, InReady}), 64'b10);
        #2 rst = 1'b0;
        #1;
        chk("rst_outvalid", 64'(OutValid), 64'd0);
        chk("rst_inready", 64'(InReady), 64'd1);
        exp_q.delete();
        id_q.delete();
        @(negedge clk);
        rst      = 1'b1;
        OutReady = 1'b1;
        @(posedge clk);
        #1;
        send(33'h1_0000_0100, 1'b1, 1'b0, 8'd127, ex(23'h0, 8'd128, 1, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        chk("post_rst_edge1", 64'(OutValid), 64'd0);
        @(negedge clk);
        chk("post_rst_edge2", 64'(OutValid), 64'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpaddsub_normalize_module.md
# fpaddsub_normalize_module

Post-add normalization stage for the single-precision FP add/sub datapath. It sits directly downstream of the mantissa execution stage and consumes its 33-bit `Sum`, `PSgn` and `Opr`, together with the larger operand's exponent. Each result is normalized with a leading-zero count and shift, the exponent is adjusted, and the result is presented with guard/round/sticky bits to the rounding stage. It is a 2-stage pipeline with valid/ready flow control.

## Interface
- No parameters; widths fixed for IEEE-754 binary32.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `InValid`  in  1  upstream has a result this cycle.
- `InReady`  out  1  block accepts the input this cycle.
- `Sum`  in  33  execution result: [32] carry, [31] hidden bit, [30:8] fraction, [7:0] extension.
- `PSgn`  in  1  result sign from execution stage.
- `Opr`  in  1  effective operation (0 add, 1 sub).
- `Emax`  in  8  biased exponent of larger operand, guaranteed 1..254.
- `OutValid`  out  1  output bundle valid.
- `OutReady`  in  1  downstream accepts the bundle.
- `NormM`  out  23  normalized fraction (hidden bit dropped).
- `NormE`  out  8  adjusted biased exponent.
- `G`, `R`, `S`  out  1 each  guard, round, sticky.
- `Sign`  out  1  result sign.
- `Zero`, `Ovf`, `Unf`  out  1 each  exact zero, exponent overflow, underflow flags.

## Operation
- Transfer at input when `InValid && InReady`; at output when `OutValid && OutReady`.
- Stage 1 registers `Sum`, `PSgn`, `Opr`, `Emax` and a 6-bit leading-zero count `Lzc` of `Sum[32:0]` (0..33).
- Stage 2 registers the normalized outputs:
  - `Sum==0`: `Zero=1`, `NormM=0`, `NormE=0`, G/R/S=0, `Sign = Opr ? 0 : PSgn`.
  - `Sum[32]=1`: shift right 1, `NormE=Emax+1`. `S` ORs in the bit shifted out. If `Emax+1==255`: `Ovf=1`, `NormE=255`, `NormM=0`, G/R/S=0.
  - Otherwise: shift left by `Lzc-1`, `NormE=Emax-(Lzc-1)`. If `Emax-(Lzc-1) < 1`, the underflow rule applies (see Configuration).
  - The 24-bit window [31:8] of the shifted value gives `NormM=[30:8]`, `G=[7]`, `R=[6]`, `S=|[5:0]`. Left shifts fill with zeros.
  - `Sign=PSgn` for nonzero results.
- Exponent arithmetic is done in 10 bits signed; no wrap-around is allowed to reach `NormE`.

## Timing
- Reset clears both stage valid bits. `OutValid=0`, `InReady=1`, and all data outputs and flags reset to 0.
- Latency: input accepted at edge N appears with `OutValid=1` after edge N+1.
- Throughput: 1 per cycle when `OutReady=1`.
- Elastic pipeline:
  - Stage 2 loads when it is empty or draining.
  - Stage 1 loads when it is empty or advancing.
  - `InReady = !s1_valid || s2_advance`.
- Simultaneous input accept and output drain with both stages full gives no bubble and no loss.
- Output data holds stable while `OutValid && !OutReady`.
- Asserting `rst` mid-stream discards in-flight results immediately. There is no partial output.

## Configuration
- `FPADDSUB_NORM_DENORM_EN` defined: underflow yields a subnormal.
  - Left shift is limited to `Emax-1`, `NormE=0`, and `Unf=1` only if the result fraction is inexact (G|R|S).
- Undefined: flush-to-zero.
  - `Unf=1`, `NormM=0`, `NormE=0`, G/R/S=0, `Zero=0`, `Sign=PSgn`.

## Test plan
- Identity: `Sum=33'h0_8000_0000`, `Emax=127` -> `NormM=0`, `NormE=127`, G/R/S=0, after 2 edges.
- Carry: `Sum=33'h1_0000_0100`, `Emax=127` -> `NormE=128`, `NormM=0`, `G=1`. With `Emax=254` -> `Ovf=1`, `NormE=255`.
- Cancellation: `Sum=33'h0_0000_8000`, `Emax=100` (`Lzc=17`) -> `NormE=84`, `NormM=0`. Zero case: `Sum=0`, `Opr=1`, `PSgn=1` -> `Zero=1`, `Sign=0`.
- Underflow: `Sum=33'h0_0000_8000`, `Emax=3`.
  - With macro -> `NormE=0`, `NormM=23'h000200`, `Unf=0`.
  - Without macro -> `Unf=1`, `NormM=0`, `NormE=0`.
- Backpressure: `OutReady=0` for 5 cycles while presenting 3 inputs -> `InReady` drops after 2 accepted. On release, all 3 results emerge in order, unchanged.
- Reset mid-stream: `rst` low with both stages full -> `OutValid=0` at once. After release, the first new input emerges after 2 edges.
